// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller
// Description : Stall / flush / freeze controller for the five-stage MIPS
//               pipeline. Combines load-use and branch-operand interlocks,
//               a mult/div busy window and a data-memory wait/timeout FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller #(
  parameter int MULDIV_LATENCY = 8,
  parameter int MEM_TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRs,
  input  logic        ID_UsesRt,
  input  logic        ID_Branch,
  input  logic        ID_BranchTaken,
  input  logic        ID_Jump,
  input  logic        ID_MulDiv,
  input  logic        ID_UsesHiLo,
  input  logic        EX_MemRead,
  input  logic        EX_RegWrite,
  input  logic [4:0]  EX_WriteRegister,
  input  logic        EX_MulDivStart,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemAccess,
  input  logic [4:0]  MEM_WriteRegister,
  input  logic        MEM_Ready,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        ID_EX_Write,
  output logic        EX_MEM_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Bubble,
  output logic        MEM_WB_Bubble,
  output logic        MulDivBusy,
  output logic        MemTimeout,
  output logic [31:0] StallCount
);

  localparam logic [7:0]  MD_LAT     = 8'(MULDIV_LATENCY);
  localparam logic [16:0] TIMEOUT_LV = 17'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } mem_state_t;

  mem_state_t   mem_state_q;
  logic [15:0]  wait_cnt_q;
  logic [16:0]  wait_cnt_inc;
  logic         mem_timeout_q;
  logic [7:0]   md_cnt_q, md_cnt_d;
  logic [31:0]  stall_cnt_q, stall_cnt_d;

  logic freeze;
  logic stall;
  logic flush;
  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;

  // Wait counter holds the number of consecutive not-ready cycles seen so
  // far; ERR is taken when the current not-ready cycle brings it to the limit.
  assign wait_cnt_inc = {1'b0, wait_cnt_q} + 17'd1;

  // Memory wait FSM: RUN -> WAIT on a stalled access, back on ready, ERR on timeout
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_state_q   <= S_RUN;
      wait_cnt_q    <= 16'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      case (mem_state_q)
        S_RUN: begin
          if (MEM_MemAccess && !MEM_Ready) begin
            wait_cnt_q <= 16'd1;
            if (TIMEOUT_LV == 17'd1) begin
              mem_state_q   <= S_ERR;
              mem_timeout_q <= 1'b1;
            end else begin
              mem_state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (MEM_Ready) begin
            mem_state_q <= S_RUN;
            wait_cnt_q  <= 16'd0;
          end else begin
            wait_cnt_q <= wait_cnt_inc[15:0];
            if (wait_cnt_inc == TIMEOUT_LV) begin
              mem_state_q   <= S_ERR;
              mem_timeout_q <= 1'b1;
            end
          end
        end
        S_ERR: begin
          mem_state_q   <= S_ERR;
          mem_timeout_q <= 1'b1;
        end
        default: begin
          mem_state_q <= S_RUN;
          wait_cnt_q  <= 16'd0;
        end
      endcase
    end
  end

  assign MemTimeout = mem_timeout_q;

  // Freeze is Mealy: a completing cycle in WAIT writes normally
  assign freeze = (mem_state_q == S_ERR)
               || ((mem_state_q == S_WAIT) && !MEM_Ready)
               || ((mem_state_q == S_RUN) && MEM_MemAccess && !MEM_Ready);

  assign MulDivBusy = (md_cnt_q != 8'd0);

  // Register 0 is hardwired and never creates a dependency
  assign ex_hit_rs  = (EX_WriteRegister  != 5'd0) && (EX_WriteRegister  == ID_Rs);
  assign ex_hit_rt  = (EX_WriteRegister  != 5'd0) && (EX_WriteRegister  == ID_Rt);
  assign mem_hit_rs = (MEM_WriteRegister != 5'd0) && (MEM_WriteRegister == ID_Rs);
  assign mem_hit_rt = (MEM_WriteRegister != 5'd0) && (MEM_WriteRegister == ID_Rt);

  // Interlock detection; branches compare in ID so they need both operands
  always_comb begin
    stall = 1'b0;
    if (!freeze) begin
      stall = (EX_MemRead && ((ex_hit_rs && ID_UsesRs) || (ex_hit_rt && ID_UsesRt)))
           || (ID_Branch && EX_RegWrite && (ex_hit_rs || ex_hit_rt))
           || (ID_Branch && MEM_MemRead && (mem_hit_rs || mem_hit_rt))
           || (MulDivBusy && (ID_MulDiv || ID_UsesHiLo));
    end
  end

  assign flush = !freeze && !stall && (ID_Jump || (ID_Branch && ID_BranchTaken));

  // Pipeline control outputs, priority freeze > stall > flush > normal
  always_comb begin
    PC_Write      = 1'b0;
    IF_ID_Write   = 1'b0;
    ID_EX_Write   = 1'b0;
    EX_MEM_Write  = 1'b0;
    IF_ID_Flush   = 1'b0;
    ID_EX_Bubble  = 1'b0;
    MEM_WB_Bubble = 1'b0;
    if (reset) begin
      if (freeze) begin
        MEM_WB_Bubble = 1'b1;
      end else if (stall) begin
        ID_EX_Write  = 1'b1;
        EX_MEM_Write = 1'b1;
        ID_EX_Bubble = 1'b1;
      end else begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Write  = 1'b1;
        EX_MEM_Write = 1'b1;
        IF_ID_Flush  = flush;
      end
    end
  end

  // Mult/div busy counter: reload only when the starting op actually advances
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (EX_MulDivStart && EX_MEM_Write) begin
      md_cnt_d = MD_LAT;
    end else if (md_cnt_q != 8'd0) begin
      md_cnt_d = md_cnt_q - 8'd1;
    end
  end

  // Saturating count of cycles in which the PC is held
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PC_Write && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt_q    <= 8'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_controller
// Description : Self-checking bench: directed vector table, hand-written
//               multi-cycle sequences and a randomized run against a
//               behavioural model of the hazard rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

  localparam int MD_LAT  = 8;
  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  ID_Rs, ID_Rt, EX_WriteRegister, MEM_WriteRegister;
  logic        ID_UsesRs, ID_UsesRt, ID_Branch, ID_BranchTaken, ID_Jump;
  logic        ID_MulDiv, ID_UsesHiLo, EX_MemRead, EX_RegWrite, EX_MulDivStart;
  logic        MEM_MemRead, MEM_MemAccess, MEM_Ready;
  logic        PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
  logic        IF_ID_Flush, ID_EX_Bubble, MEM_WB_Bubble, MulDivBusy, MemTimeout;
  logic [31:0] StallCount;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int     m_md_rem;
  int     m_waited;
  bit     m_err;
  longint m_sc;

  pipeline_hazard_controller #(.MULDIV_LATENCY(MD_LAT), .MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump),
    .ID_MulDiv(ID_MulDiv), .ID_UsesHiLo(ID_UsesHiLo),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite),
    .EX_WriteRegister(EX_WriteRegister), .EX_MulDivStart(EX_MulDivStart),
    .MEM_MemRead(MEM_MemRead), .MEM_MemAccess(MEM_MemAccess),
    .MEM_WriteRegister(MEM_WriteRegister), .MEM_Ready(MEM_Ready),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .ID_EX_Write(ID_EX_Write),
    .EX_MEM_Write(EX_MEM_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Bubble(ID_EX_Bubble), .MEM_WB_Bubble(MEM_WB_Bubble),
    .MulDivBusy(MulDivBusy), .MemTimeout(MemTimeout), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt, br, bt, jmp, exmr, exrw;
    logic [4:0] exwr;
    logic       memmr;
    logic [4:0] memwr;
    logic       stall, flush;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ID_Rs = '0; ID_Rt = '0; ID_UsesRs = 0; ID_UsesRt = 0; ID_Branch = 0;
    ID_BranchTaken = 0; ID_Jump = 0; ID_MulDiv = 0; ID_UsesHiLo = 0;
    EX_MemRead = 0; EX_RegWrite = 0; EX_WriteRegister = '0; EX_MulDivStart = 0;
    MEM_MemRead = 0; MEM_MemAccess = 0; MEM_WriteRegister = '0; MEM_Ready = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_PC_Write"},      {31'd0, PC_Write},      32'd0);
    chk({tag, "_IF_ID_Write"},   {31'd0, IF_ID_Write},   32'd0);
    chk({tag, "_ID_EX_Write"},   {31'd0, ID_EX_Write},   32'd0);
    chk({tag, "_EX_MEM_Write"},  {31'd0, EX_MEM_Write},  32'd0);
    chk({tag, "_IF_ID_Flush"},   {31'd0, IF_ID_Flush},   32'd0);
    chk({tag, "_ID_EX_Bubble"},  {31'd0, ID_EX_Bubble},  32'd0);
    chk({tag, "_MEM_WB_Bubble"}, {31'd0, MEM_WB_Bubble}, 32'd0);
    chk({tag, "_MulDivBusy"},    {31'd0, MulDivBusy},    32'd0);
    chk({tag, "_MemTimeout"},    {31'd0, MemTimeout},    32'd0);
    chk({tag, "_StallCount"},    StallCount,             32'd0);
  endtask

  // Hold reset across one clock edge, then release with idle inputs
  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m_md_rem = 0; m_waited = 0; m_err = 0; m_sc = 0;
  endtask

  function automatic bit reads(input logic [4:0] r);
    return (r != 0) && ((r == ID_Rs && ID_UsesRs) || (r == ID_Rt && ID_UsesRt));
  endfunction

  function automatic bit sources(input logic [4:0] r);
    return (r != 0) && (r == ID_Rs || r == ID_Rt);
  endfunction

  // Reference: classify the cycle, check every output, then advance the model
  task automatic model_cycle();
    bit f, s, fl;
    f  = m_err || (!MEM_Ready && (m_waited > 0 || MEM_MemAccess));
    s  = !f && ((EX_MemRead && reads(EX_WriteRegister))
             || (ID_Branch && EX_RegWrite && sources(EX_WriteRegister))
             || (ID_Branch && MEM_MemRead && sources(MEM_WriteRegister))
             || (m_md_rem > 0 && (ID_MulDiv || ID_UsesHiLo)));
    fl = !f && !s && (ID_Jump || (ID_Branch && ID_BranchTaken));
    chk("rnd_PC_Write",      {31'd0, PC_Write},      {31'd0, !f && !s});
    chk("rnd_IF_ID_Write",   {31'd0, IF_ID_Write},   {31'd0, !f && !s});
    chk("rnd_ID_EX_Write",   {31'd0, ID_EX_Write},   {31'd0, !f});
    chk("rnd_EX_MEM_Write",  {31'd0, EX_MEM_Write},  {31'd0, !f});
    chk("rnd_IF_ID_Flush",   {31'd0, IF_ID_Flush},   {31'd0, fl});
    chk("rnd_ID_EX_Bubble",  {31'd0, ID_EX_Bubble},  {31'd0, s});
    chk("rnd_MEM_WB_Bubble", {31'd0, MEM_WB_Bubble}, {31'd0, f});
    chk("rnd_MulDivBusy",    {31'd0, MulDivBusy},    {31'd0, m_md_rem > 0});
    chk("rnd_MemTimeout",    {31'd0, MemTimeout},    {31'd0, m_err});
    chk("rnd_StallCount",    StallCount,             32'(m_sc));
    if (EX_MulDivStart && !f) m_md_rem = MD_LAT;
    else if (m_md_rem > 0)    m_md_rem--;
    if ((f || s) && m_sc < 64'hFFFF_FFFF) m_sc++;
    if (!m_err) begin
      if (m_waited == 0) begin
        if (MEM_MemAccess && !MEM_Ready) m_waited = 1;
      end else if (MEM_Ready) begin
        m_waited = 0;
      end else begin
        m_waited++;
      end
      if (m_waited >= TIMEOUT) m_err = 1;
    end
  endtask

  initial begin
    vecs[0]  = '{5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b1, 1'b0};
    vecs[1]  = '{5'd0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0};
    vecs[2]  = '{5'd0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b1, 1'b0};
    vecs[3]  = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0};
    vecs[4]  = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1};
    vecs[5]  = '{5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 1'b0};
    vecs[6]  = '{5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0};
    vecs[7]  = '{5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1};
    vecs[8]  = '{5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0};
    vecs[9]  = '{5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 1'b0};
    vecs[10] = '{5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0};
    vecs[11] = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1};
    vecs[12] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 5'd0, 1'b1, 1'b0};

    // Reset values while reset is held
    clear_inputs();
    #2;
    check_reset_vals("rst");
    do_reset();

    // Single-cycle interlock / flush vectors from an idle pipeline
    for (int i = 0; i < 13; i++) begin
      clear_inputs();
      MEM_Ready = 1'b1;
      ID_Rs = vecs[i].rs; ID_Rt = vecs[i].rt; ID_UsesRs = vecs[i].urs; ID_UsesRt = vecs[i].urt;
      ID_Branch = vecs[i].br; ID_BranchTaken = vecs[i].bt; ID_Jump = vecs[i].jmp;
      EX_MemRead = vecs[i].exmr; EX_RegWrite = vecs[i].exrw; EX_WriteRegister = vecs[i].exwr;
      MEM_MemRead = vecs[i].memmr; MEM_WriteRegister = vecs[i].memwr;
      #2;
      chk($sformatf("vec%0d_PC_Write", i),     {31'd0, PC_Write},      {31'd0, !vecs[i].stall});
      chk($sformatf("vec%0d_IF_ID_Write", i),  {31'd0, IF_ID_Write},   {31'd0, !vecs[i].stall});
      chk($sformatf("vec%0d_ID_EX_Bubble", i), {31'd0, ID_EX_Bubble},  {31'd0, vecs[i].stall});
      chk($sformatf("vec%0d_IF_ID_Flush", i),  {31'd0, IF_ID_Flush},   {31'd0, vecs[i].flush});
      chk($sformatf("vec%0d_EX_MEM_Write", i), {31'd0, EX_MEM_Write},  32'd1);
      chk($sformatf("vec%0d_MEM_WB_Bubble", i),{31'd0, MEM_WB_Bubble}, 32'd0);
      tick();
    end

    // Load-use: exactly one bubble, StallCount 1
    do_reset();
    ID_Rs = 5'd8; ID_UsesRs = 1'b1; EX_MemRead = 1'b1; EX_WriteRegister = 5'd8; MEM_Ready = 1'b1;
    #2;
    chk("lu_PC_Write", {31'd0, PC_Write}, 32'd0);
    tick();
    EX_MemRead = 1'b0; EX_WriteRegister = 5'd0;
    #2;
    chk("lu_PC_Write_after", {31'd0, PC_Write}, 32'd1);
    chk("lu_StallCount", StallCount, 32'd1);

    // Branch after ALU producer, then after load, then taken
    do_reset();
    MEM_Ready = 1'b1; ID_Branch = 1'b1; ID_Rs = 5'd9; ID_UsesRs = 1'b1;
    EX_RegWrite = 1'b1; EX_WriteRegister = 5'd9;
    #2;
    chk("br1_ID_EX_Bubble", {31'd0, ID_EX_Bubble}, 32'd1);
    tick();
    EX_RegWrite = 1'b0; EX_WriteRegister = 5'd0; MEM_MemRead = 1'b1; MEM_WriteRegister = 5'd9;
    #2;
    chk("br2_PC_Write", {31'd0, PC_Write}, 32'd0);
    tick();
    MEM_MemRead = 1'b0; MEM_WriteRegister = 5'd0; ID_BranchTaken = 1'b1;
    #2;
    chk("br3_IF_ID_Flush", {31'd0, IF_ID_Flush}, 32'd1);
    chk("br3_PC_Write", {31'd0, PC_Write}, 32'd1);
    tick();
    clear_inputs(); MEM_Ready = 1'b1;
    #2;
    chk("br_IF_ID_Flush_off", {31'd0, IF_ID_Flush}, 32'd0);
    chk("br_StallCount", StallCount, 32'd2);

    // Mult/div busy window: 8 stalled cycles, released on the 9th
    do_reset();
    MEM_Ready = 1'b1; EX_MulDivStart = 1'b1; ID_UsesHiLo = 1'b1;
    #2;
    chk("md0_PC_Write", {31'd0, PC_Write}, 32'd1);
    tick();
    EX_MulDivStart = 1'b0;
    for (int c = 1; c <= MD_LAT; c++) begin
      #2;
      chk($sformatf("md%0d_PC_Write", c),   {31'd0, PC_Write},   32'd0);
      chk($sformatf("md%0d_MulDivBusy", c), {31'd0, MulDivBusy}, 32'd1);
      tick();
    end
    #2;
    chk("md_release_PC_Write", {31'd0, PC_Write},   32'd1);
    chk("md_release_Busy",     {31'd0, MulDivBusy}, 32'd0);
    chk("md_StallCount",       StallCount,          32'd8);

    // Memory wait: three frozen cycles then the ready cycle writes
    do_reset();
    MEM_MemAccess = 1'b1; MEM_Ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("mw%0d_MEM_WB_Bubble", c), {31'd0, MEM_WB_Bubble}, 32'd1);
      chk($sformatf("mw%0d_EX_MEM_Write", c),  {31'd0, EX_MEM_Write},  32'd0);
      tick();
    end
    MEM_Ready = 1'b1;
    #2;
    chk("mw_ready_MEM_WB_Bubble", {31'd0, MEM_WB_Bubble}, 32'd0);
    chk("mw_ready_PC_Write",      {31'd0, PC_Write},      32'd1);
    tick();
    MEM_MemAccess = 1'b0;
    #2;
    chk("mw_StallCount", StallCount, 32'd3);

    // Timeout: ERR after TIMEOUT not-ready cycles, only reset recovers
    do_reset();
    MEM_MemAccess = 1'b1; MEM_Ready = 1'b0;
    for (int c = 0; c < TIMEOUT; c++) begin
      #2;
      chk($sformatf("to%0d_MemTimeout", c), {31'd0, MemTimeout}, 32'd0);
      chk($sformatf("to%0d_PC_Write", c),   {31'd0, PC_Write},   32'd0);
      tick();
    end
    MEM_MemAccess = 1'b0; MEM_Ready = 1'b1;
    #2;
    chk("to_MemTimeout",    {31'd0, MemTimeout},    32'd1);
    chk("to_err_freeze",    {31'd0, MEM_WB_Bubble}, 32'd1);
    tick();
    #2;
    chk("to_err_held",      {31'd0, PC_Write},      32'd0);
    reset = 1'b0;
    #2;
    check_reset_vals("to_rst");
    tick();
    reset = 1'b1;
    #2;
    chk("to_after_rst_PC_Write", {31'd0, PC_Write}, 32'd1);
    tick();

    // Randomized run against the behavioural model
    do_reset();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        clear_inputs();
        reset = 1'b0;
        #2;
        check_reset_vals("rnd_rst");
        tick();
        reset = 1'b1;
        m_md_rem = 0; m_waited = 0; m_err = 0; m_sc = 0;
      end else begin
        ID_Rs             = 5'($urandom_range(0, 3));
        ID_Rt             = 5'($urandom_range(0, 3));
        ID_UsesRs         = 1'($urandom_range(0, 1));
        ID_UsesRt         = 1'($urandom_range(0, 1));
        ID_Branch         = ($urandom_range(0, 3) == 0);
        ID_BranchTaken    = 1'($urandom_range(0, 1));
        ID_Jump           = ($urandom_range(0, 7) == 0);
        ID_MulDiv         = ($urandom_range(0, 5) == 0);
        ID_UsesHiLo       = ($urandom_range(0, 3) == 0);
        EX_MemRead        = ($urandom_range(0, 2) == 0);
        EX_RegWrite       = 1'($urandom_range(0, 1));
        EX_WriteRegister  = 5'($urandom_range(0, 3));
        EX_MulDivStart    = ($urandom_range(0, 9) == 0);
        MEM_MemRead       = ($urandom_range(0, 2) == 0);
        MEM_MemAccess     = ($urandom_range(0, 3) == 0);
        MEM_WriteRegister = 5'($urandom_range(0, 3));
        MEM_Ready         = ($urandom_range(0, 9) < 7);
        #2;
        model_cycle();
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
